// File: rtl/dwt_line_sequencer.sv
// Front-end sequencer for the 9/7 lifting unit: packs raster samples into {odd, even}
// beats, flags sof/eol and appends one mirrored symmetric-extension beat per line.
module dwt_line_sequencer #(
  parameter int unsigned DataWidth       = 16,
  parameter int unsigned MaximumSideSize = 512,
  localparam int unsigned SizeW          = $clog2(MaximumSideSize) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_start_i,
  input  logic [SizeW-1:0]       cfg_width_i,
  input  logic [SizeW-1:0]       cfg_height_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [DataWidth-1:0]   s_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2,
    EXT  = 2'd3
  } state_e;

  state_e                       state_q, state_d;
  logic [SizeW-1:0]             width_q, width_d;
  logic [SizeW-1:0]             height_q, height_d;
  logic [SizeW-1:0]             pair_cnt_q, pair_cnt_d;
  logic [SizeW-1:0]             line_cnt_q, line_cnt_d;
  logic [DataWidth-1:0]         even_q, even_d;
  // Index 2 is the newest sample of the line, index 0 the oldest of the three.
  logic [2:0][DataWidth-1:0]    hist_q, hist_d;
  logic                         m_valid_q, m_valid_d;
  logic                         m_sof_q, m_sof_d;
  logic                         m_eol_q, m_eol_d;
  logic                         m_last_q, m_last_d;
  logic [2*DataWidth-1:0]       m_data_q, m_data_d;
  logic                         err_q, err_d;

  logic out_free;
  logic cfg_legal;
  logic last_pair;
  logic last_line;

  assign out_free  = ~m_valid_q | m_ready_i;
  assign last_pair = (pair_cnt_q == ((width_q >> 1) - SizeW'(1)));
  assign last_line = (line_cnt_q == (height_q - SizeW'(1)));
  assign cfg_legal = ~cfg_width_i[0]
                   & (cfg_width_i >= SizeW'(4))
                   & (cfg_width_i <= SizeW'(MaximumSideSize))
                   & (cfg_height_i != '0)
                   & (cfg_height_i <= SizeW'(MaximumSideSize));

  assign s_ready_o = (state_q == EVEN) | ((state_q == ODD) & out_free);
  assign busy_o    = (state_q != IDLE) | m_valid_q;
  // The final EXT beat carries m_last; done coincides with its handshake.
  assign done_o    = m_valid_q & m_ready_i & m_last_q;
  assign err_o     = err_q;
  assign m_valid_o = m_valid_q;
  assign m_sof_o   = m_sof_q;
  assign m_eol_o   = m_eol_q;
  assign m_data_o  = m_data_q;

  // Next-state, counters, sample history and output register load.
  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    pair_cnt_d = pair_cnt_q;
    line_cnt_d = line_cnt_q;
    even_d     = even_q;
    hist_d     = hist_q;
    m_valid_d  = m_valid_q;
    m_sof_d    = m_sof_q;
    m_eol_d    = m_eol_q;
    m_last_d   = m_last_q;
    m_data_d   = m_data_q;
    err_d      = 1'b0;

    if (m_valid_q && m_ready_i) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cfg_start_i && !m_valid_q) begin
          if (cfg_legal) begin
            width_d    = cfg_width_i;
            height_d   = cfg_height_i;
            pair_cnt_d = '0;
            line_cnt_d = '0;
            state_d    = EVEN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EVEN: begin
        if (s_valid_i) begin
          even_d  = s_data_i;
          hist_d  = {s_data_i, hist_q[2], hist_q[1]};
          state_d = ODD;
        end
      end
      ODD: begin
        if (s_valid_i && out_free) begin
          hist_d    = {s_data_i, hist_q[2], hist_q[1]};
          m_valid_d = 1'b1;
          m_data_d  = {s_data_i, even_q};
          m_sof_d   = (pair_cnt_q == '0) && (line_cnt_q == '0);
          m_eol_d   = 1'b0;
          m_last_d  = 1'b0;
          if (last_pair) begin
            pair_cnt_d = '0;
            state_d    = EXT;
          end else begin
            pair_cnt_d = pair_cnt_q + SizeW'(1);
            state_d    = EVEN;
          end
        end
      end
      EXT: begin
        // Mirrored pair x[N], x[N+1] = x[N-2], x[N-3].
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = {hist_q[0], hist_q[1]};
          m_sof_d   = 1'b0;
          m_eol_d   = 1'b1;
          m_last_d  = last_line;
          if (last_line) begin
            state_d = IDLE;
          end else begin
            line_cnt_d = line_cnt_q + SizeW'(1);
            state_d    = EVEN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      width_q    <= '0;
      height_q   <= '0;
      pair_cnt_q <= '0;
      line_cnt_q <= '0;
      even_q     <= '0;
      hist_q     <= '0;
      m_valid_q  <= 1'b0;
      m_sof_q    <= 1'b0;
      m_eol_q    <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      pair_cnt_q <= pair_cnt_d;
      line_cnt_q <= line_cnt_d;
      even_q     <= even_d;
      hist_q     <= hist_d;
      m_valid_q  <= m_valid_d;
      m_sof_q    <= m_sof_d;
      m_eol_q    <= m_eol_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_dwt_line_sequencer.sv
// Bench for dwt_line_sequencer: directed frames with random data/backpressure,
// compared beat by beat against a queue-based model of the beat sequence.
module tb_dwt_line_sequencer;

  localparam int unsigned DW      = 16;
  localparam int unsigned MaxSide = 512;
  localparam int unsigned SW      = $clog2(MaxSide) + 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            cfg_start_i = 1'b0;
  logic [SW-1:0]   cfg_width_i = '0;
  logic [SW-1:0]   cfg_height_i = '0;
  logic            busy_o, done_o, err_o;
  logic            s_valid_i = 1'b0;
  logic            s_ready_o;
  logic [DW-1:0]   s_data_i = '0;
  logic            m_valid_o;
  logic            m_ready_i = 1'b0;
  logic            m_sof_o, m_eol_o;
  logic [2*DW-1:0] m_data_o;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0]   samp[$];
  logic [2*DW-1:0] exp_data[$];
  logic            exp_sof[$];
  logic            exp_eol[$];

  dwt_line_sequencer #(.DataWidth(DW), .MaximumSideSize(MaxSide)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cfg_start_i  (cfg_start_i),
    .cfg_width_i  (cfg_width_i),
    .cfg_height_i (cfg_height_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_data_i     (s_data_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_sof_o      (m_sof_o),
    .m_eol_o      (m_eol_o),
    .m_data_o     (m_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_seq(input int first, input int n);
    samp = {};
    for (int i = 0; i < n; i++) samp.push_back(DW'(first + i));
  endtask

  task automatic fill_rand(input int n);
    samp = {};
    for (int i = 0; i < n; i++) samp.push_back(DW'($urandom));
  endtask

  // Reference: every line gives pairs (x[2k+1], x[2k]) then the mirrored pair (x[W-3], x[W-2]).
  task automatic build_expect(input int w, input int h);
    exp_data = {};
    exp_sof  = {};
    exp_eol  = {};
    for (int l = 0; l < h; l++) begin
      int base;
      base = l * w;
      for (int k = 0; k < w / 2; k++) begin
        exp_data.push_back({samp[base + 2*k + 1], samp[base + 2*k]});
        exp_sof.push_back(l == 0 && k == 0);
        exp_eol.push_back(1'b0);
      end
      exp_data.push_back({samp[base + w - 3], samp[base + w - 2]});
      exp_sof.push_back(1'b0);
      exp_eol.push_back(1'b1);
    end
  endtask

  task automatic start_cfg(input int w, input int h, input bit legal);
    @(negedge clk_i);
    cfg_start_i  = 1'b1;
    cfg_width_i  = SW'(w);
    cfg_height_i = SW'(h);
    @(negedge clk_i);
    cfg_start_i = 1'b0;
    #1;
    if (legal) begin
      check("start_busy", 64'(busy_o), 64'(1));
      check("start_s_ready", 64'(s_ready_o), 64'(1));
      check("start_no_err", 64'(err_o), 64'(0));
    end else begin
      check("illegal_err", 64'(err_o), 64'(1));
      check("illegal_busy", 64'(busy_o), 64'(0));
      check("illegal_s_ready", 64'(s_ready_o), 64'(0));
      @(negedge clk_i);
      #1;
      check("illegal_err_single", 64'(err_o), 64'(0));
      check("illegal_busy_after", 64'(busy_o), 64'(0));
      check("illegal_s_ready_after", 64'(s_ready_o), 64'(0));
    end
  endtask

  task automatic run_frame(input int w, input int h, input bit rnd,
                           input int mid_start, input int abort_after);
    int bi, si, last_hs_cyc, budget;
    bit aborted, held, out_hs, in_hs;
    logic [2*DW-1:0] held_data;
    logic held_sof, held_eol;
    build_expect(w, h);
    bi = 0; si = 0; last_hs_cyc = -1; aborted = 0; held = 0;
    held_data = '0; held_sof = 0; held_eol = 0;
    budget = 40 * (w + 1) * h + 100;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (bi >= exp_data.size()) break;
      @(negedge clk_i);
      m_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (si < samp.size()) begin
        s_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        s_data_i  = samp[si];
      end else begin
        s_valid_i = 1'b0;
        s_data_i  = '0;
      end
      cfg_start_i = (cyc == mid_start);
      if (cyc == mid_start) begin
        cfg_width_i  = SW'(16);
        cfg_height_i = SW'(1);
      end
      #1;
      if (mid_start >= 0 && cyc == mid_start + 1) begin
        check("busy_start_no_err", 64'(err_o), 64'(0));
        check("busy_start_still_busy", 64'(busy_o), 64'(1));
      end
      if (held) begin
        check("stall_valid", 64'(m_valid_o), 64'(1));
        check("stall_data", 64'(m_data_o), 64'(held_data));
        check("stall_sof", 64'(m_sof_o), 64'(held_sof));
        check("stall_eol", 64'(m_eol_o), 64'(held_eol));
      end
      if ((si % 2) == 1 && m_valid_o && !m_ready_i)
        check("stall_s_ready_low", 64'(s_ready_o), 64'(0));
      out_hs = m_valid_o && m_ready_i;
      in_hs  = s_valid_i && s_ready_o;
      if (out_hs) begin
        if (bi < exp_data.size()) begin
          check("beat_data", 64'(m_data_o), 64'(exp_data[bi]));
          check("beat_sof", 64'(m_sof_o), 64'(exp_sof[bi]));
          check("beat_eol", 64'(m_eol_o), 64'(exp_eol[bi]));
          check("beat_done", 64'(done_o), 64'(bi == exp_data.size() - 1));
        end else begin
          check("extra_beat", 64'(1), 64'(0));
        end
        bi++;
        last_hs_cyc = cyc;
      end else begin
        check("done_quiet", 64'(done_o), 64'(0));
      end
      held      = m_valid_o && !m_ready_i;
      held_data = m_data_o;
      held_sof  = m_sof_o;
      held_eol  = m_eol_o;
      if (in_hs) si++;
      if (abort_after > 0 && si == abort_after) begin
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      s_valid_i   = 1'b0;
      cfg_start_i = 1'b0;
      check("frame_beat_count", 64'(bi), 64'(exp_data.size()));
      if (!rnd) check("frame_cycles", 64'(last_hs_cyc), 64'(h * (w + 1)));
      @(negedge clk_i);
      #1;
      check("frame_end_busy", 64'(busy_o), 64'(0));
      check("frame_end_valid", 64'(m_valid_o), 64'(0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy_o), 64'(0));
    check({tag, "_done"}, 64'(done_o), 64'(0));
    check({tag, "_err"}, 64'(err_o), 64'(0));
    check({tag, "_s_ready"}, 64'(s_ready_o), 64'(0));
    check({tag, "_m_valid"}, 64'(m_valid_o), 64'(0));
    check({tag, "_sof"}, 64'(m_sof_o), 64'(0));
    check({tag, "_eol"}, 64'(m_eol_o), 64'(0));
    check({tag, "_data"}, 64'(m_data_o), 64'(0));
  endtask

  initial begin
    int w, h;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check_all_zero("reset");

    // Nominal frame, 1..16, no backpressure
    fill_seq(1, 16);
    start_cfg(8, 2, 1);
    run_frame(8, 2, 0, -1, 0);

    // Same frame with random ready and valid
    fill_seq(1, 16);
    start_cfg(8, 2, 1);
    run_frame(8, 2, 1, -1, 0);

    // Minimum width
    fill_seq(5, 4);
    start_cfg(4, 1, 1);
    run_frame(4, 1, 0, -1, 0);

    // Width 6 is legal
    fill_rand(6);
    start_cfg(6, 1, 1);
    run_frame(6, 1, 1, -1, 0);

    // Illegal configurations
    start_cfg(7, 1, 0);
    start_cfg(2, 1, 0);
    start_cfg(8, 0, 0);
    start_cfg(514, 1, 0);
    start_cfg(8, 513, 0);

    // Start while busy is ignored
    fill_rand(16);
    start_cfg(8, 2, 1);
    run_frame(8, 2, 1, 5, 0);

    // Random frames
    repeat (4) begin
      w = 2 * $urandom_range(2, 16);
      h = $urandom_range(1, 3);
      fill_rand(w * h);
      start_cfg(w, h, 1);
      run_frame(w, h, 1, -1, 0);
    end

    // Reset after three samples of line 0, then the nominal frame again
    fill_seq(1, 16);
    start_cfg(8, 2, 1);
    run_frame(8, 2, 0, -1, 3);
    @(negedge clk_i);
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    check_all_zero("midreset");
    rst_i = 1'b0;
    fill_seq(1, 16);
    start_cfg(8, 2, 1);
    run_frame(8, 2, 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
